// File: rtl/pixel_frame_reader.sv
// pixel_frame_reader: streams a 1-bit-per-pixel frame out of a synchronous
// pixel RAM one row at a time. Each row is fetched pixel by pixel into a
// packed row register, then offered to the consumer with a valid/ready
// handshake. Addresses are produced by a running increment only.
module pixel_frame_reader #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic              q,
  output logic [IMG_W-1:0]  row_data,
  output logic [4:0]        row_idx,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              busy,
  output logic              done
);

  // Column counter runs 0..IMG_W inclusive: IMG_W address cycles plus one
  // trailing cycle to catch the last pixel out of the RAM pipeline.
  localparam int COL_W = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PUSH  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q;
  logic             last_row;
  logic             launch;

  assign last_row = (row_idx == 5'(IMG_H - 1));
  // abort has priority over start while idle
  assign launch   = start && !abort;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (launch) state_d = FETCH;
      FETCH: begin
        if (abort)                          state_d = IDLE;
        else if (col_q == COL_W'(IMG_W))    state_d = PUSH;
      end
      PUSH: begin
        if (abort)          state_d = IDLE;
        else if (row_ready) state_d = last_row ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register, so reset clears
  // them immediately without waiting for a clock.
  assign row_valid = (state_q == PUSH);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Datapath: address walk, column count, row capture and row index.
  // rdaddress doubles as the row base: it parks on the row's last pixel
  // during PUSH and one increment lands on the next row's first pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdaddress <= '0;
      col_q     <= '0;
      row_data  <= '0;
      row_idx   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            rdaddress <= '0;
            col_q     <= '0;
            row_idx   <= '0;
          end
        end
        FETCH: begin
          // RAM data lags the address by one cycle: column c arrives when
          // the counter reads c+1.
          for (int c = 0; c < IMG_W; c++) begin
            if (col_q == COL_W'(c + 1)) row_data[c] <= q;
          end
          if (col_q == COL_W'(IMG_W)) col_q <= '0;
          else                        col_q <= col_q + COL_W'(1);
          // Stop on the row's last pixel so the frame never overruns.
          if (col_q < COL_W'(IMG_W - 1)) rdaddress <= rdaddress + ADDR_W'(1);
        end
        PUSH: begin
          if (!abort && row_ready && !last_row) begin
            row_idx   <= row_idx + 5'd1;
            rdaddress <= rdaddress + ADDR_W'(1);
            col_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Directed bench for pixel_frame_reader: synchronous 1-bit RAM model,
// hand-computed expected rows, handshake/stall/abort/reset scenarios.
module tb_pixel_frame_reader;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int ADDR_W = 10;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rdaddress;
  logic              q;
  logic [IMG_W-1:0]  row_data;
  logic [4:0]        row_idx;
  logic              row_valid;
  logic              row_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  bit              ram [0:(1<<ADDR_W)-1];
  logic [IMG_W-1:0] exp_rows [IMG_H];

  pixel_frame_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .rdaddress (rdaddress),
    .q         (q),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: data for the address seen at an edge appears after it.
  always @(posedge clock) q <= ram[rdaddress];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic fill_checker();
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) ram[r*IMG_W + c] = bit'((r + c) % 2);
      exp_rows[r] = (r % 2 == 0) ? 28'hAAAAAAA : 28'h5555555;
    end
  endtask

  task automatic fill_row5();
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) ram[r*IMG_W + c] = (r == 5);
      exp_rows[r] = (r == 5) ? 28'hFFFFFFF : 28'h0;
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < IMG_H; r++) begin
      exp_rows[r] = '0;
      for (int c = 0; c < IMG_W; c++) begin
        ram[r*IMG_W + c] = bit'($urandom_range(0, 1));
        exp_rows[r][c]   = ram[r*IMG_W + c];
      end
    end
  endtask

  // Pulse start for one sampling edge; returns at the negedge of cycle 0.
  task automatic start_frame();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Runs from the negedge of cycle 0 (first cycle after the start-sampling
  // edge). Arguments < 0 disable the corresponding feature.
  task automatic run_frame(input int stall_row, input int stall_len, input bit rnd,
                           input int repulse, input int abort_at, input int reset_at,
                           input int exp_done);
    int   rows_seen  = 0;
    int   exp_addr   = 0;
    int   addr_err   = 0;
    int   stall_left = 0;
    int   late_done  = 0;
    bit   stalled    = 0;
    bit   pend       = 0;
    bit   finished   = 0;
    logic [IMG_W-1:0] held_data = '0;
    logic [4:0]       held_idx  = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) @(negedge clock);
      if (n == 0) check("busy_after_start", busy, 1);
      start = (repulse >= 0) && (n == repulse || n == repulse + 1);

      if (busy) begin
        if (rdaddress == ADDR_W'(exp_addr)) exp_addr++;
        else if (rdaddress != ADDR_W'(exp_addr - 1)) addr_err++;
      end

      if (n == abort_at) begin
        check("abort_row_idx", row_idx, 12);
        check("abort_in_fetch", row_valid, 0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", row_valid, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          if (done || busy) late_done++;
        end
        check("abort_stays_idle", late_done, 0);
        finished = 1;
        break;
      end

      if (n == reset_at) begin
        check("rst_push_valid", row_valid, 1);
        check("rst_push_idx", row_idx, 3);
        row_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_addr", rdaddress, 0);
        check("rst_async_data", row_data, 0);
        check("rst_async_idx", row_idx, 0);
        check("rst_async_valid", row_valid, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_done", done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("rst_idle_busy", busy, 0);
        check("rst_idle_valid", row_valid, 0);
        check("rst_idle_addr", rdaddress, 0);
        finished = 1;
        break;
      end

      if (done) begin
        if (exp_done >= 0) check("done_cycle", n, exp_done);
        check("rows_at_done", rows_seen, IMG_H);
        check("busy_in_done", busy, 1);
        check("addr_seq_errors", addr_err, 0);
        check("addr_count", exp_addr, IMG_W*IMG_H);
        @(negedge clock);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        finished = 1;
        break;
      end

      if (pend) begin
        check("stall_valid", row_valid, 1);
        check("stall_data", row_data, held_data);
        check("stall_idx", row_idx, held_idx);
      end

      if (row_valid) begin
        if (!stalled && row_idx == 5'(stall_row)) begin
          stalled    = 1;
          stall_left = stall_len;
        end
        if (stall_left > 0) begin
          row_ready = 1'b0;
          stall_left--;
        end else begin
          row_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (row_ready) begin
          if (rows_seen < IMG_H) begin
            check($sformatf("row%0d_data", rows_seen), row_data, exp_rows[rows_seen]);
            check($sformatf("row%0d_idx", rows_seen), row_idx, rows_seen);
          end else begin
            check("extra_row", row_idx, 0);
          end
          rows_seen++;
          pend = 0;
        end else begin
          pend      = 1;
          held_data = row_data;
          held_idx  = row_idx;
        end
      end else begin
        row_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (!finished) check("frame_timeout", 0, 1);
    start = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b1;
    start     = 1'b1;
    abort     = 1'b0;
    row_ready = 1'b1;
    fill_checker();

    // Reset applied asynchronously, checked before any clock edge.
    #1 reset_n = 1'b0;
    #2;
    check("reset_addr", rdaddress, 0);
    check("reset_data", row_data, 0);
    check("reset_idx", row_idx, 0);
    check("reset_valid", row_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Checkerboard frame; start held high through reset release, plus a
    // stray start pulse mid-frame that must change nothing.
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start = 1'b0;
    run_frame(-1, 0, 1'b0, 100, -1, -1, 840);
    check("addr_held_idle", rdaddress, 783);

    // start together with abort in IDLE is ignored.
    @(negedge clock);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 0);
    @(negedge clock);
    check("start_abort_idle2", busy, 0);

    // Row 5 all ones, consumer stalls 10 cycles on it.
    fill_row5();
    start_frame();
    run_frame(5, 10, 1'b0, -1, -1, -1, 850);

    // Abort during FETCH of row 12 (row 12 starts at cycle 360).
    fill_checker();
    start_frame();
    run_frame(-1, 0, 1'b0, -1, 365, -1, -1);

    // Restart after abort with random data and random back-pressure.
    fill_random();
    start_frame();
    run_frame(-1, 0, 1'b1, -1, -1, -1, -1);

    // Asynchronous reset during PUSH of row 3 (cycle 3*30+29).
    fill_checker();
    row_ready = 1'b1;
    start_frame();
    run_frame(-1, 0, 1'b0, -1, -1, 119, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
